// File: rtl/dual_seq_generator.sv
// Serial pattern transmitter: sends N frames of 101 or 0110 MSB-first with GAP idle cycles between frames.
// Latency 1 from command accept to first bit; cmd_ready is low for the whole command except its done cycle.
module dual_seq_generator #(
  parameter int   CNT_W    = 4,
  parameter int   GAP      = 1,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_sel,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAPS} state_t;

  state_t             state, state_nxt;
  logic               sel_q, sel_nxt;
  logic [1:0]         bit_idx, bit_idx_nxt;
  logic [CNT_W-1:0]   frames_left, frames_nxt, frames_dec;
  logic [GAP_W-1:0]   gap_cnt, gap_nxt;
  logic               dout_nxt, valid_nxt, done_nxt;
  logic               accept, last_bit, last_frame, gap_end;

  // sel=0 -> 1,0,1 ; sel=1 -> 0,1,1,0
  function automatic logic pat_bit(input logic sel, input logic [1:0] idx);
    if (sel) pat_bit = (idx == 2'd1) || (idx == 2'd2);
    else     pat_bit = (idx != 2'd1);
  endfunction

  assign cmd_ready  = (state == IDLE) && reset;
  assign busy       = (state != IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign last_bit   = (bit_idx == (sel_q ? 2'd3 : 2'd2));
  assign frames_dec = (frames_left != '0) ? frames_left - 1'b1 : frames_left;
  assign last_frame = (frames_dec == '0);
  assign gap_end    = (gap_cnt == '0);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && (cmd_count != '0)) state_nxt = SEND;
      SEND: begin
        if (last_bit) begin
          if (last_frame)   state_nxt = IDLE;
          else if (GAP > 0) state_nxt = GAPS;
        end
      end
      GAPS:    if (gap_end) state_nxt = SEND;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_nxt     = sel_q;
    bit_idx_nxt = bit_idx;
    frames_nxt  = frames_left;
    gap_nxt     = gap_cnt;
    dout_nxt    = IDLE_BIT;
    valid_nxt   = 1'b0;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          sel_nxt     = cmd_sel;
          frames_nxt  = cmd_count;
          bit_idx_nxt = 2'd0;
          if (cmd_count != '0) begin
            dout_nxt  = pat_bit(cmd_sel, 2'd0);
            valid_nxt = 1'b1;
          end else begin
            done_nxt  = 1'b1;
          end
        end
      end
      SEND: begin
        if (!last_bit) begin
          bit_idx_nxt = bit_idx + 2'd1;
          dout_nxt    = pat_bit(sel_q, bit_idx + 2'd1);
          valid_nxt   = 1'b1;
        end else begin
          frames_nxt  = frames_dec;
          bit_idx_nxt = 2'd0;
          if (last_frame) begin
            done_nxt = 1'b1;
          end else if (GAP > 0) begin
            gap_nxt  = GAP_W'(GAP - 1);
          end else begin
            // back-to-back frames: keep valid high into next bit 0
            dout_nxt  = pat_bit(sel_q, 2'd0);
            valid_nxt = 1'b1;
          end
        end
      end
      GAPS: begin
        if (gap_end) begin
          dout_nxt  = pat_bit(sel_q, 2'd0);
          valid_nxt = 1'b1;
        end else begin
          gap_nxt   = gap_cnt - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_q       <= 1'b0;
      bit_idx     <= 2'd0;
      frames_left <= '0;
      gap_cnt     <= '0;
      dout        <= IDLE_BIT;
      dout_valid  <= 1'b0;
      done        <= 1'b0;
    end else begin
      sel_q       <= sel_nxt;
      bit_idx     <= bit_idx_nxt;
      frames_left <= frames_nxt;
      gap_cnt     <= gap_nxt;
      dout        <= dout_nxt;
      dout_valid  <= valid_nxt;
      done        <= done_nxt;
    end
  end

endmodule

// File: tb/tb_dual_seq_generator.sv
// Bench for dual_seq_generator: two instances (GAP=0 and GAP=1) on shared command inputs,
// each checked every cycle against a queue-based frame model, plus literal stream/latency checks.
module tb_dual_seq_generator;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_sel;
  logic [3:0] cmd_count;

  logic rdy_w[2], dout_w[2], dv_w[2], busy_w[2], done_w[2];

  int n_checks = 0;
  int n_fail   = 0;

  int          nval[2];
  int          ngap[2];
  logic [63:0] cap[2];

  always #5 clk = ~clk;

  dual_seq_generator #(.CNT_W(4), .GAP(0)) u_gap0 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy_w[0]),
    .cmd_sel(cmd_sel), .cmd_count(cmd_count), .dout(dout_w[0]),
    .dout_valid(dv_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );

  dual_seq_generator #(.CNT_W(4), .GAP(1)) u_gap1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy_w[1]),
    .cmd_sel(cmd_sel), .cmd_count(cmd_count), .dout(dout_w[1]),
    .dout_valid(dv_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic v;
    logic d;
    logic b;
    logic dn;
  } exp_t;

  function automatic exp_t mk(input logic v, input logic d, input logic b, input logic dn);
    exp_t e;
    e.v = v; e.d = d; e.b = b; e.dn = dn;
    return e;
  endfunction

  // Per-instance model: on accept, expand the command into the full per-cycle output schedule.
  for (genvar g = 0; g < 2; g++) begin : mdl
    localparam int GP = g;
    exp_t q[$];
    exp_t cur;
    bit   live = 1'b0;
    int   pv, len;

    always @(posedge clk) begin
      if (!reset) begin
        q.delete();
        cur  = mk(1'b0, 1'b0, 1'b0, 1'b0);
        live = 1'b1;
      end else if (live) begin
        if (cmd_valid && !cur.b) begin
          pv  = cmd_sel ? 6 : 5;
          len = cmd_sel ? 4 : 3;
          q.delete();
          for (int f = 1; f <= int'(cmd_count); f++) begin
            for (int i = 0; i < len; i++) q.push_back(mk(1'b1, pv[len-1-i], 1'b1, 1'b0));
            if (f < int'(cmd_count))
              for (int k = 0; k < GP; k++) q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
          end
          q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1));
        end
        cur = (q.size() > 0) ? q.pop_front() : mk(1'b0, 1'b0, 1'b0, 1'b0);
      end
    end

    always @(negedge clk) begin
      if (live) begin
        check($sformatf("g%0d dout", g),       64'(dout_w[g]), 64'(cur.d));
        check($sformatf("g%0d dout_valid", g), 64'(dv_w[g]),   64'(cur.v));
        check($sformatf("g%0d busy", g),       64'(busy_w[g]), 64'(cur.b));
        check($sformatf("g%0d done", g),       64'(done_w[g]), 64'(cur.dn));
        check($sformatf("g%0d cmd_ready", g),  64'(rdy_w[g]),  64'(reset && !cur.b));
      end
      if (dv_w[g] === 1'b1) begin
        nval[g]++;
        cap[g] = {cap[g][62:0], dout_w[g]};
      end else if (busy_w[g] === 1'b1) begin
        ngap[g]++;
      end
    end
  end

  // Present a command, wait for the chosen instance to take it; returns in cycle 1 after accept.
  task automatic accept_cmd(input logic sel, input logic [3:0] cnt, input int inst);
    int guard;
    guard     = 0;
    cmd_sel   = sel;
    cmd_count = cnt;
    cmd_valid = 1'b1;
    @(negedge clk);
    while (rdy_w[inst] !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("accept wait", 64'(rdy_w[inst]), 64'd1);
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
    nval[inst] = 0;
    ngap[inst] = 0;
    cap[inst]  = '0;
  endtask

  // Count cycles until done; optionally keep cmd_valid high with a toggling cmd_sel.
  task automatic wait_done(input int inst, input int hold, output int lat);
    lat = 1;
    while (done_w[inst] !== 1'b1 && lat < 300) begin
      if (lat <= hold) begin
        cmd_valid = 1'b1;
        cmd_sel   = ~cmd_sel;
      end else begin
        cmd_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    cmd_valid = 1'b0;
    check("done seen", 64'(done_w[inst]), 64'd1);
  endtask

  initial begin
    int lat;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_sel   = 1'b0;
    cmd_count = 4'd0;
    for (int i = 0; i < 2; i++) begin nval[i] = 0; ngap[i] = 0; cap[i] = '0; end
    repeat (2) @(posedge clk);
    #1;
    check("reset dout_valid", 64'(dv_w[1]), 64'd0);
    check("reset cmd_ready",  64'(rdy_w[1]), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // 101 once, GAP=1
    accept_cmd(1'b0, 4'd1, 1);
    wait_done(1, 0, lat);
    check("t1 latency", 64'(lat), 64'd4);
    check("t1 bits", cap[1], 64'b101);
    check("t1 nvalid", 64'(nval[1]), 64'd3);

    // 0110 twice with one gap cycle
    accept_cmd(1'b1, 4'd2, 1);
    wait_done(1, 0, lat);
    check("t2 latency", 64'(lat), 64'd10);
    check("t2 bits", cap[1], 64'b0110_0110);
    check("t2 gaps", 64'(ngap[1]), 64'd1);

    // count=0 on both selects
    accept_cmd(1'b0, 4'd0, 1);
    wait_done(1, 0, lat);
    check("t3a latency", 64'(lat), 64'd1);
    check("t3a nvalid", 64'(nval[1]), 64'd0);
    accept_cmd(1'b1, 4'd0, 1);
    wait_done(1, 0, lat);
    check("t3b latency", 64'(lat), 64'd1);

    // GAP=0 back-to-back frames, then a command accepted in the done cycle
    accept_cmd(1'b0, 4'd3, 0);
    wait_done(0, 0, lat);
    check("t4 latency", 64'(lat), 64'd10);
    check("t4 bits", cap[0], 64'b101_101_101);
    check("t4 nvalid", 64'(nval[0]), 64'd9);
    accept_cmd(1'b1, 4'd1, 0);
    wait_done(0, 0, lat);
    check("t4b latency", 64'(lat), 64'd5);
    check("t4b bits", cap[0], 64'b0110);

    // reset in the middle of frame 2, bit 2
    accept_cmd(1'b1, 4'd5, 1);
    repeat (7) begin @(posedge clk); #1; end
    check("t5 mid dout", 64'(dout_w[1]), 64'd1);
    check("t5 mid valid", 64'(dv_w[1]), 64'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("t5 rst valid", 64'(dv_w[1]), 64'd0);
    check("t5 rst busy", 64'(busy_w[1]), 64'd0);
    check("t5 rst done", 64'(done_w[1]), 64'd0);
    reset = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    accept_cmd(1'b1, 4'd1, 1);
    wait_done(1, 0, lat);
    check("t5 fresh latency", 64'(lat), 64'd5);
    check("t5 fresh bits", cap[1], 64'b0110);

    // maximum count, inputs wiggled while busy
    accept_cmd(1'b0, 4'd15, 1);
    wait_done(1, 20, lat);
    check("t6 latency", 64'(lat), 64'd60);
    check("t6 nvalid", 64'(nval[1]), 64'd45);
    check("t6 gaps", 64'(ngap[1]), 64'd14);
    check("t6 last bits", cap[1] & 64'h3F, 64'b101_101);

    repeat (30) begin @(posedge clk); #1; end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_seq_generator.md
Name: dual_seq_generator

Overview:
Serial pattern transmitter that drives the dual sequence detector (101 / 0110) and other serial-input blocks.
- Accepts a command over a valid/ready handshake: which pattern to send, and how many frames.
- Emits the pattern MSB-first on a 1-bit serial output, one bit per clock, with a programmable idle gap between frames.
- Pulses a completion flag when the command is finished.

Parameters:
CNT_W, 4, width of the frame-count field.
GAP, 1, idle cycles inserted between consecutive frames of one command (0 = frames back-to-back).
IDLE_BIT, 1'b0, value driven on dout whenever dout_valid=0.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  synchronous active-low reset: low at a rising edge resets the block.
cmd_valid  input  1  command present.
cmd_ready  output  1  block can accept a command; combinational, = (state==IDLE) && reset.
cmd_sel  input  1  0 selects pattern 101 (L=3); 1 selects pattern 0110 (L=4).
cmd_count  input  CNT_W  number of frames to send, 0..2^CNT_W-1.
dout  output  1  serial data bit, registered.
dout_valid  output  1  dout carries a pattern bit this cycle, registered.
busy  output  1  high in SEND or GAP states.
done  output  1  one-cycle pulse, registered, after a command completes.

Behaviour:
- Reset (reset=0 at a rising edge) from any state, including mid-frame:
  - state=IDLE; dout=IDLE_BIT; dout_valid=0; done=0; bit index and frame counter cleared.
  - cmd_ready is forced 0 while reset is low; commands presented then are ignored.
  - No done pulse is generated for an interrupted command.
- States:
  - IDLE: cmd_ready=1, busy=0, dout_valid=0.
  - SEND: busy=1, dout_valid=1.
  - GAP: busy=1, dout_valid=0, dout=IDLE_BIT.
- Command acceptance:
  - Accept on the edge where cmd_valid && cmd_ready.
  - Latch cmd_sel and cmd_count at that edge; later input changes have no effect.
- count=0: stay in IDLE; done=1 in the next cycle; dout_valid stays 0.
- count>0: go to SEND at the accepting edge, with dout loaded with pattern bit 0 at that same edge.
  - First bit is visible the cycle immediately after the accept edge (latency 1).
- SEND:
  - Each edge advances the bit index 0..L-1. Bit order: 101 gives 1,0,1; 0110 gives 0,1,1,0.
  - At the edge leaving bit L-1, frames_left is decremented:
    - frames_left reaches 0: go to IDLE; done=1 for exactly the next cycle; dout_valid=0 in that cycle.
    - otherwise, GAP>0: go to GAP for exactly GAP cycles, then SEND at bit 0.
    - otherwise, GAP=0: bit 0 of the next frame follows immediately, with dout_valid held high.
- Totals per command with count N:
  - dout_valid high for exactly N*L cycles.
  - Gap cycles = (N-1)*GAP.
  - done arrives N*L + (N-1)*GAP + 1 cycles after the accept edge.
- Back-to-back commands:
  - cmd_ready is high in the done cycle, so a new command may be accepted there.
  - Its first bit appears in the following cycle; there are no dead cycles other than the done cycle.
- Counter rules:
  - frames_left is CNT_W bits and never wraps: decrement happens only when nonzero.
  - Max count = 2^CNT_W-1, which must be supported fully (15 frames at the default).
- busy, cmd_ready and dout_valid are mutually consistent in every cycle:
  - busy = !(state==IDLE).
  - dout_valid implies busy.
- Outputs contain no X after the first reset edge.

Test Plan:
1. Reset low 2 cycles, then high; sel=0, count=1 (GAP=1) -> dout/valid = 1/1, 0/1, 1/1 on cycles 1-3 after accept; done=1 on cycle 4; cmd_ready=0 on cycles 1-3.
2. sel=1, count=2, GAP=1 -> valid stream 0,1,1,0, then one cycle valid=0 with dout=IDLE_BIT, then 0,1,1,0; done on cycle 10 after accept.
3. count=0, either sel -> no dout_valid; done pulse on the cycle after accept; cmd_ready high throughout.
4. GAP=0, sel=0, count=3 -> 9 consecutive valid cycles 1,0,1,1,0,1,1,0,1; immediately accept sel=1, count=1 in the done cycle -> 0,1,1,0 starts on the next cycle.
5. sel=1, count=5; drive reset low at bit 2 of frame 2 -> next cycle dout_valid=0, busy=0, no done pulse; a fresh command after reset release starts from bit 0, frame 1.
6. count=15, sel=0, GAP=1 -> exactly 45 valid cycles and 14 gap cycles; done at cycle 60 after accept; hold cmd_valid high and change cmd_sel mid-run -> no effect on the current command.
